// File: rtl/hwpe_stream_tcdm_responder.sv
// TCDM target: word-interleaved banked scratchpad with per-bank round-robin
// arbitration and a fixed one-cycle response (r_valid/r_data) for reads and writes.
module hwpe_stream_tcdm_responder #(
  parameter int unsigned NB_CHAN    = 4,
  parameter int unsigned NB_BANKS   = 4,
  parameter int unsigned BANK_DEPTH = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic [NB_CHAN-1:0]      tcdm_req_i,
  input  logic [NB_CHAN*32-1:0]   tcdm_add_i,
  input  logic [NB_CHAN-1:0]      tcdm_wen_i,
  input  logic [NB_CHAN*4-1:0]    tcdm_be_i,
  input  logic [NB_CHAN*32-1:0]   tcdm_data_i,
  output logic [NB_CHAN-1:0]      tcdm_gnt_o,
  output logic [NB_CHAN*32-1:0]   tcdm_r_data_o,
  output logic [NB_CHAN-1:0]      tcdm_r_valid_o
);

  localparam int unsigned LogBanks = $clog2(NB_BANKS);
  localparam int unsigned BankW    = (NB_BANKS > 1) ? LogBanks : 1;
  localparam int unsigned RowW     = $clog2(BANK_DEPTH);
  localparam int unsigned ChanW    = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1;

  logic [BankW-1:0] chan_bank [NB_CHAN];
  logic [RowW-1:0]  chan_row  [NB_CHAN];

  logic [NB_CHAN-1:0]  gnt;
  logic [NB_BANKS-1:0] win_valid;
  logic [ChanW-1:0]    win_idx [NB_BANKS];
  logic [ChanW-1:0]    idx;

  logic [RowW-1:0] bank_row   [NB_BANKS];
  logic            bank_we    [NB_BANKS];
  logic [3:0]      bank_be    [NB_BANKS];
  logic [31:0]     bank_wdata [NB_BANKS];
  logic [31:0]     bank_rdata [NB_BANKS];

  logic [31:0]        mem_q [NB_BANKS][BANK_DEPTH];
  logic [ChanW-1:0]   ptr_q [NB_BANKS];
  logic [NB_CHAN-1:0] r_valid_q;
  logic [31:0]        r_data_q [NB_CHAN];

  // Upper word bits fall off the row index, so addresses alias and wrap.
  for (genvar c = 0; c < NB_CHAN; c++) begin : g_chan
    logic [29:0] word;
    logic        unused_lsb;
    assign word         = tcdm_add_i[c*32+2 +: 30];
    assign chan_bank[c] = BankW'(word & 30'(NB_BANKS - 1));
    assign chan_row[c]  = RowW'(word >> LogBanks);
    assign unused_lsb   = ^tcdm_add_i[c*32 +: 2];

    assign tcdm_r_data_o[c*32 +: 32] = r_data_q[c];
  end

  // Per bank, the first requester at or after the pointer wins.
  always_comb begin
    gnt       = '0;
    win_valid = '0;
    idx       = '0;
    for (int unsigned b = 0; b < NB_BANKS; b++) begin
      win_idx[b] = '0;
      for (int unsigned off = 0; off < NB_CHAN; off++) begin
        idx = ChanW'((32'(ptr_q[b]) + off) % NB_CHAN);
        if (!win_valid[b] && !clear_i && tcdm_req_i[idx] && chan_bank[idx] == BankW'(b)) begin
          win_valid[b] = 1'b1;
          win_idx[b]   = idx;
          gnt[idx]     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < NB_BANKS; b++) begin
      bank_row[b]   = chan_row[win_idx[b]];
      bank_we[b]    = win_valid[b] && !tcdm_wen_i[win_idx[b]];
      bank_be[b]    = tcdm_be_i[win_idx[b]*4 +: 4];
      bank_wdata[b] = tcdm_data_i[win_idx[b]*32 +: 32];
      bank_rdata[b] = mem_q[b][bank_row[b]];
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int unsigned b = 0; b < NB_BANKS; b++) begin
      if (bank_we[b]) begin
        for (int unsigned j = 0; j < 4; j++) begin
          if (bank_be[b][j]) begin
            mem_q[b][bank_row[b]][8*j +: 8] <= bank_wdata[b][8*j +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= '0;
      for (int unsigned c = 0; c < NB_CHAN; c++) r_data_q[c] <= '0;
      for (int unsigned b = 0; b < NB_BANKS; b++) ptr_q[b] <= '0;
    end else if (clear_i) begin
      r_valid_q <= '0;
      for (int unsigned c = 0; c < NB_CHAN; c++) r_data_q[c] <= '0;
      for (int unsigned b = 0; b < NB_BANKS; b++) ptr_q[b] <= '0;
    end else begin
      r_valid_q <= gnt;
      for (int unsigned c = 0; c < NB_CHAN; c++) begin
        if (gnt[c]) begin
          r_data_q[c] <= tcdm_wen_i[c] ? bank_rdata[chan_bank[c]] : 32'h0;
        end
      end
      for (int unsigned b = 0; b < NB_BANKS; b++) begin
        if (win_valid[b]) begin
          ptr_q[b] <= ChanW'((32'(win_idx[b]) + 1) % NB_CHAN);
        end
      end
    end
  end

  assign tcdm_gnt_o     = gnt;
  assign tcdm_r_valid_o = r_valid_q;

endmodule

// File: tb/tb_hwpe_stream_tcdm_responder.sv
// Bench for hwpe_stream_tcdm_responder: per-cycle vector table with expected grants
// and read data, a response scoreboard, plus a hand-written reset sequence.
module tb_hwpe_stream_tcdm_responder;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic [3:0]       req, wen, gnt, r_valid;
  logic [3:0][31:0] add, data, r_data;
  logic [3:0][3:0]  be;

  hwpe_stream_tcdm_responder #(
    .NB_CHAN   (4),
    .NB_BANKS  (4),
    .BANK_DEPTH(256)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .tcdm_req_i    (req),
    .tcdm_add_i    (add),
    .tcdm_wen_i    (wen),
    .tcdm_be_i     (be),
    .tcdm_data_i   (data),
    .tcdm_gnt_o    (gnt),
    .tcdm_r_data_o (r_data),
    .tcdm_r_valid_o(r_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             clear;
    logic [3:0]       req;
    logic [3:0]       wen;
    logic [3:0][3:0]  be;
    logic [3:0][31:0] add;
    logic [3:0][31:0] data;
    logic [3:0]       exp_gnt;
    logic [3:0][31:0] exp_rd;
  } vec_t;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] data;
  } sb_t;

  vec_t             vecs[$];
  vec_t             cur;
  sb_t              sb[$];
  logic [3:0][31:0] exp_last;
  int               passed = 0;
  int               total  = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic vbegin(bit clr = 1'b0);
    cur       = '0;
    cur.clear = clr;
  endtask

  task automatic vch(int c, bit rd, logic [31:0] a, logic [31:0] d, logic [3:0] b, bit g,
                     logic [31:0] erd = 32'h0);
    cur.req[c]  = 1'b1;
    cur.wen[c]  = rd;
    cur.add[c]  = a;
    cur.data[c] = d;
    cur.be[c]   = b;
    if (g) begin
      cur.exp_gnt[c] = 1'b1;
      cur.exp_rd[c]  = rd ? erd : 32'h0;
    end
  endtask

  task automatic vend();
    vecs.push_back(cur);
  endtask

  task automatic apply(vec_t v);
    clear = v.clear;
    req   = v.req;
    wen   = v.wen;
    add   = v.add;
    data  = v.data;
    be    = v.be;
  endtask

  // Responses due now were pushed one cycle earlier; idle channels must hold r_data.
  task automatic check_resp(int n);
    logic [3:0] exp_rv;
    sb_t        e;
    exp_rv = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      exp_rv[e.ch]   = 1'b1;
      exp_last[e.ch] = e.data;
    end
    check($sformatf("r_valid v%0d", n), 128'(r_valid), 128'(exp_rv));
    for (int c = 0; c < 4; c++) begin
      check($sformatf("r_data[%0d] v%0d", c, n), 128'(r_data[c]), 128'(exp_last[c]));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    exp_last = '0;
    apply('0);

    // ch, rd, add, data, be, expect-grant, expected read data
    vbegin(); vch(0, 0, 32'h10, 32'hDEADBEEF, 4'hF, 1);                 vend(); // 0
    vbegin(); vch(0, 1, 32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF);          vend(); // 1
    vbegin(); vch(0, 0, 32'h20, 32'h11223344, 4'hF, 1);                 vend(); // 2
    vbegin(); vch(0, 0, 32'h20, 32'hAABBCCDD, 4'b0101, 1);              vend(); // 3
    vbegin(); vch(0, 1, 32'h20, 32'h0, 4'h0, 1, 32'h11BB33DD);          vend(); // 4
    vbegin(); vch(0, 0, 32'h0, 32'hCAFE0001, 4'hF, 1);                  vend(); // 5
    vbegin(); vch(0, 1, 32'h1000, 32'h0, 4'h0, 1, 32'hCAFE0001);        vend(); // 6
    vbegin(); vch(1, 0, 32'h30, 32'h30303030, 4'hF, 1);                 vend(); // 7
    vbegin(); vch(2, 1, 32'h30, 32'h0, 4'h0, 1, 32'h30303030);          vend(); // 8
    vbegin(1); vch(0, 0, 32'h10, 32'h0, 4'hF, 0);
               vch(1, 1, 32'h10, 32'h0, 4'h0, 0);                       vend(); // 9
    vbegin(); vch(1, 1, 32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF);
              vch(3, 1, 32'h0, 32'h0, 4'h0, 0);                         vend(); // 10
    vbegin(); vch(3, 1, 32'h0, 32'h0, 4'h0, 1, 32'hCAFE0001);           vend(); // 11
    for (int k = 0; k < 4; k++) begin                                           // 12..15
      vbegin();
      vch(0, 1, 32'h0,  32'h0, 4'h0, k == 0, 32'hCAFE0001);
      vch(1, 1, 32'h10, 32'h0, 4'h0, k == 1, 32'hDEADBEEF);
      vch(2, 1, 32'h20, 32'h0, 4'h0, k == 2, 32'h11BB33DD);
      vch(3, 1, 32'h30, 32'h0, 4'h0, k == 3, 32'h30303030);
      vend();
    end
    vbegin(); vch(0, 0, 32'h4, 32'h44444444, 4'hF, 1);
              vch(1, 0, 32'h8, 32'h88888888, 4'hF, 1);
              vch(2, 0, 32'hC, 32'hCCCCCCCC, 4'hF, 1);
              vch(3, 0, 32'h0, 32'h0000F00D, 4'hF, 1);                  vend(); // 16
    vbegin(); vch(0, 1, 32'h0, 32'h0, 4'h0, 1, 32'h0000F00D);
              vch(1, 1, 32'h4, 32'h0, 4'h0, 1, 32'h44444444);
              vch(2, 1, 32'h8, 32'h0, 4'h0, 1, 32'h88888888);
              vch(3, 1, 32'hC, 32'h0, 4'h0, 1, 32'hCCCCCCCC);           vend(); // 17
    vbegin(); vch(1, 0, 32'h4, 32'hFFFFFFFF, 4'h0, 1);                  vend(); // 18
    vbegin(); vch(1, 1, 32'h4, 32'h0, 4'h0, 1, 32'h44444444);           vend(); // 19
    vbegin(); vch(0, 0, 32'h4, 32'h0, 4'hF, 0); cur.req = '0;           vend(); // 20
    vbegin(); vch(1, 1, 32'h4, 32'h0, 4'h0, 1, 32'h44444444);           vend(); // 21

    // Reset state
    #2;
    check("reset r_valid", 128'(r_valid), 128'h0);
    check("reset r_data", 128'(r_data), 128'h0);
    check("reset gnt", 128'(gnt), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      apply(vecs[n]);
      #1;
      check_resp(n);
      check($sformatf("gnt v%0d", n), 128'(gnt), 128'(vecs[n].exp_gnt));
      for (int c = 0; c < 4; c++) begin
        if (vecs[n].exp_gnt[c]) sb.push_back('{ch: 2'(c), data: vecs[n].exp_rd[c]});
      end
      if (vecs[n].clear) exp_last = '0;
    end
    @(negedge clk);
    apply('0);
    #1;
    check_resp(vecs.size());

    // Asynchronous reset while a read response is on the outputs
    @(negedge clk);
    req[0] = 1'b1; wen[0] = 1'b1; add[0] = 32'h10;
    #1;
    check("pre-reset gnt", 128'(gnt), 128'h1);
    @(posedge clk);
    #2;
    check("pre-reset r_valid", 128'(r_valid), 128'h1);
    check("pre-reset r_data", 128'(r_data[0]), 128'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check("async reset r_valid", 128'(r_valid), 128'h0);
    check("async reset r_data", 128'(r_data), 128'h0);
    // Bank 0 pointer was 1 before reset; after reset ch0 must beat ch1
    req[1] = 1'b1; wen[1] = 1'b1; add[1] = 32'h20;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-reset rr gnt", 128'(gnt), 128'h1);
    @(posedge clk);
    #2;
    check("post-reset r_valid", 128'(r_valid), 128'h1);
    @(negedge clk);
    apply('0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_tcdm_responder.md
Name: hwpe_stream_tcdm_responder

Overview:
Multi-port TCDM responder: the memory end of the hwpe_stream_intf_tcdm protocol, answering requests from HWPE streamers or reorder blocks. It holds a word-interleaved banked scratchpad and arbitrates per bank with round-robin priority. It returns grant, r_valid and r_data with fixed single-cycle read latency. It serves as a self-contained TCDM target for cluster-less integration and for HWPE block-level benches.

Parameters:
NB_CHAN, 4, number of TCDM request channels (>=1)
NB_BANKS, 4, number of interleaved 32-bit banks (power of two, >=1)
BANK_DEPTH, 256, words per bank (power of two, >=2)

Ports:
clk_i  input  1  clock; single clock domain
rst_ni  input  1  reset, asynchronous, active-low
clear_i  input  1  synchronous soft clear
tcdm  hwpe_stream_intf_tcdm.slave  [NB_CHAN-1:0]  request channels, one field set per channel:
tcdm[i].req  input  1  request
tcdm[i].add  input  32  byte address
tcdm[i].wen  input  1  1 = read, 0 = write
tcdm[i].be  input  4  byte enables for writes
tcdm[i].data  input  32  write data
tcdm[i].gnt  output  1  grant, combinational in the request cycle
tcdm[i].r_data  output  32  read data
tcdm[i].r_valid  output  1  response valid

Behaviour:
- Address map: word = add[31:2]; bank = word[log2(NB_BANKS)-1:0]; row = (word >> log2(NB_BANKS)) mod BANK_DEPTH. Upper bits are ignored, so addresses alias and wrap. add[1:0] is ignored.
- Arbitration, per bank and per cycle: the candidates are channels with req=1 whose bank matches. At most one channel per bank is granted.
  - Each bank has an rr pointer p_b, reset to 0.
  - The winner is the first candidate scanning i = p_b, p_b+1, ... mod NB_CHAN.
  - After a grant to channel k, p_b <= (k+1) mod NB_CHAN. With no grant, p_b holds.
- gnt[i] = 1 only if channel i wins its bank and clear_i=0. It is purely combinational from req/add/pointers, with no dependency on r_valid.
- Granted write (wen=0): at the next clk edge, each byte j with be[j]=1 is written from data[8j+7:8j]. Other bytes keep their value. be=0000 is a legal no-op write that still receives a response.
- Granted read (wen=1): the row is read at the clk edge.
- Response timing:
  - r_valid[i] = 1 exactly in the cycle after gnt[i] = 1, for reads and writes alike. Otherwise it is 0.
  - For a read, r_data[i] holds the word as it was before any write in the grant cycle; a same-cycle write to the same bank is impossible, so this is simply the stored word.
  - For a write response, r_data[i] = 0.
  - In cycles with r_valid=0, r_data holds its last value.
- Back-to-back operation: a channel may be granted every cycle. Read-after-write to the same address in the next cycle returns the new data.
- Reset (rst_ni=0):
  - All r_valid go to 0, all r_data go to 0, all rr pointers go to 0.
  - Memory contents are not reset and are undefined.
  - Any in-flight response is dropped.
- clear_i=1, synchronous:
  - Suppresses all grants that cycle; no memory writes occur.
  - Next cycle: r_valid=0, r_data=0, pointers=0.
  - A response already due in the clear cycle (granted in the previous cycle) is still delivered in the clear cycle.
  - Memory is preserved.
- Requests with req=0 are ignored regardless of the other fields. A channel holding req=1 while not granted must keep waiting; the responder does not record ungranted requests.
- Starvation-free: a channel holding req to a bank is granted within NB_CHAN cycles.

Test Plan:
1. Single write then read. Stimulus: ch0 writes add=0x10, data=0xDEADBEEF, be=1111; next cycle ch0 reads 0x10. Required: gnt=1 in both cycles; r_valid=1 one cycle after each; the read returns 0xDEADBEEF.
2. Byte enables. Stimulus: write 0x11223344 to 0x20; then write 0xAABBCCDD with be=0101; then read 0x20. Required: read returns 0x11BB33DD.
3. Bank conflict and round robin. Stimulus: ch0..ch3 all hold reads of 0x0, 0x10, 0x20, 0x30 (all bank 0) for 4 cycles. Required: grants go to ch0, ch1, ch2, ch3 in order, one per cycle; each r_valid follows its grant by one cycle.
4. Parallel banks. Stimulus: ch0..ch3 read 0x0, 0x4, 0x8, 0xC simultaneously. Required: all four gnt=1 in the same cycle; all four r_valid=1 in the next cycle.
5. Aliasing. With BANK_DEPTH=256 and NB_BANKS=4, stimulus: write 0xCAFE0001 to 0x0, then read 0x1000. Required: the read returns 0xCAFE0001.
6. Reset and clear mid-operation.
   - clear_i while ch1 requests: gnt=0 that cycle; the prior cycle's read response is still delivered; the pointer is 0 next cycle; memory data is intact.
   - rst_ni pulsed low during a pending response: r_valid=0 and r_data=0 immediately, asynchronously.
